// File: rtl/stack_pkg.sv
// Shared definitions for the stack reverser: FSM encoding, default sizes and
// the count-width helper.
package stack_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stack_reverser.sv
// Frame reverser driving an external push/pop LIFO: fills it from the input
// stream, then pops one word per 3 cycles onto the output stream.
// Optional STACK_REVERSER_STATUS_EN adds sticky err and seg pulse outputs.
module stack_reverser
  import stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full
`ifdef STACK_REVERSER_STATUS_EN
  ,
  output logic             err,
  output logic             seg
`endif
);

  localparam int CW = cnt_width(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             stk_pop_q, stk_pop_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    m_valid_d = m_valid_q;
    m_last_d  = m_last_q;
    m_data_d  = m_data_q;
    s_ready   = 1'b0;
    stk_push  = 1'b0;
    case (state_q)
      FILL: begin
        s_ready  = ~stk_full & (cnt_q < DEPTH_C);
        stk_push = s_valid & s_ready;
        if (stk_push) begin
          cnt_d = cnt_q + ONE_C;
          // A full segment closes the frame even without s_last.
          if (s_last || (cnt_q == DEPTH_C - ONE_C)) state_d = POP;
        end
      end
      POP: state_d = CAP;
      CAP: begin
        m_data_d  = stk_dout;
        m_valid_d = 1'b1;
        m_last_d  = (cnt_q == ONE_C);
        cnt_d     = cnt_q - ONE_C;
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = m_last_q ? FILL : POP;
        end
      end
      default: state_d = FILL;
    endcase
    stk_pop_d = (state_d == POP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_data_q  <= '0;
      stk_pop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_data_q  <= m_data_d;
      stk_pop_q <= stk_pop_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign m_data  = m_data_q;
  assign stk_pop = stk_pop_q;
  assign stk_din = s_data;

`ifdef STACK_REVERSER_STATUS_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == POP) && stk_empty) err_d = 1'b1;
    if ((state_q == FILL) && stk_full && (cnt_q < DEPTH_C)) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
  assign seg = (state_q == FILL) & stk_push & ~s_last & (cnt_q == DEPTH_C - ONE_C);
`endif

endmodule

// File: tb/tb_stack_reverser.sv
// Directed bench for stack_reverser with a behavioural LIFO attached.
module tb_stack_reverser;

  localparam int W = 8;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid, s_ready, s_last;
  logic [W-1:0] s_data;
  logic         m_valid, m_ready, m_last;
  logic [W-1:0] m_data;
  logic         stk_push, stk_pop, stk_empty, stk_full;
  logic [W-1:0] stk_din, stk_dout;
`ifdef STACK_REVERSER_STATUS_EN
  logic         err, seg;
  int           seg_cnt = 0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int pop_cnt = 0;
  int overlap = 0;
  int pc0;

  always #5 clk = ~clk;

  stack_reverser #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .stk_push(stk_push), .stk_pop(stk_pop), .stk_din(stk_din),
    .stk_dout(stk_dout), .stk_empty(stk_empty), .stk_full(stk_full)
`ifdef STACK_REVERSER_STATUS_EN
    , .err(err), .seg(seg)
`endif
  );

  // Behavioural stack: registered read data, cleared by the same rst.
  logic [W-1:0] mem [D];
  int           sp;
  logic         force_empty = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sp       <= 0;
      stk_dout <= '0;
    end else if (stk_push && sp < D) begin
      mem[sp] <= stk_din;
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      stk_dout <= mem[sp-1];
      sp       <= sp - 1;
    end
  end

  assign stk_empty = (sp == 0) | force_empty;
  assign stk_full  = (sp == D);

  always @(posedge clk) begin
    if (stk_pop) pop_cnt <= pop_cnt + 1;
    if (stk_pop && stk_push) overlap <= overlap + 1;
`ifdef STACK_REVERSER_STATUS_EN
    if (seg) seg_cnt <= seg_cnt + 1;
`endif
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [W-1:0] d, input logic l, input string tag);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    while (!s_ready && n < 60) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 60) chk(32'(s_ready), 32'd1, {tag, "_accept_timeout"});
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic recv(input logic [W-1:0] d, input logic l, input string tag);
    int n = 0;
    while (!m_valid && n < 60) begin
      @(posedge clk); #1; n++;
    end
    chk(32'(m_valid), 32'd1, {tag, "_valid"});
    chk(32'(m_data), 32'(d), {tag, "_data"});
    chk(32'(m_last), 32'(l), {tag, "_last"});
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    @(posedge clk); #1;
    chk(32'(m_valid), 32'd0, "rst_m_valid");
    chk(32'(m_last), 32'd0, "rst_m_last");
    chk(32'(m_data), 32'd0, "rst_m_data");
    chk(32'(stk_pop), 32'd0, "rst_stk_pop");
    chk(32'(dut.cnt_q), 32'd0, "rst_cnt");
    chk(32'(s_ready), 32'd1, "rst_s_ready");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Four-word frame
    pc0 = pop_cnt;
    send(8'h11, 1'b0, "f4_w0");
    send(8'h22, 1'b0, "f4_w1");
    send(8'h33, 1'b0, "f4_w2");
    send(8'h44, 1'b1, "f4_w3");
    recv(8'h44, 1'b0, "f4_o0");
    recv(8'h33, 1'b0, "f4_o1");
    recv(8'h22, 1'b0, "f4_o2");
    recv(8'h11, 1'b1, "f4_o3");
    chk(32'(pop_cnt - pc0), 32'd4, "f4_pop_count");

    // Nine words: a full segment of eight, then a single-word frame
    for (int i = 1; i <= 8; i++) send(W'(i), 1'b0, "seg_w");
    for (int i = 8; i >= 1; i--) recv(W'(i), (i == 1), "seg_o");
    send(8'h09, 1'b1, "seg_w9");
    recv(8'h09, 1'b1, "seg_o9");
`ifdef STACK_REVERSER_STATUS_EN
    chk(32'(seg_cnt), 32'd1, "seg_pulse_count");
    chk(32'(err), 32'd0, "err_clear");
`endif

    // Single word with latency check: accept edge -> POP, CAP, then HOLD
    send(8'hAA, 1'b1, "one_w");
    chk(32'(m_valid), 32'd0, "lat_c1");
    @(posedge clk); #1;
    chk(32'(m_valid), 32'd0, "lat_c2");
    @(posedge clk); #1;
    chk(32'(m_valid), 32'd1, "lat_c3");
    recv(8'hAA, 1'b1, "one_o");

    // Backpressure in HOLD
    send(8'h11, 1'b0, "bp_w0");
    send(8'h22, 1'b0, "bp_w1");
    send(8'h33, 1'b1, "bp_w2");
    m_ready = 1'b0;
    for (int n = 0; n < 60 && !m_valid; n++) begin @(posedge clk); #1; end
    pc0 = pop_cnt;
    for (int i = 0; i < 5; i++) begin
      chk(32'(m_valid), 32'd1, "bp_valid");
      chk(32'(m_data), 32'h33, "bp_data");
      chk(32'(s_ready), 32'd0, "bp_s_ready");
      @(posedge clk); #1;
    end
    chk(32'(pop_cnt - pc0), 32'd0, "bp_no_pop");
    m_ready = 1'b1;
    @(posedge clk); #1;
    recv(8'h22, 1'b0, "bp_o1");
    recv(8'h11, 1'b1, "bp_o2");

    // Reset in HOLD after two of four outputs
    send(8'h55, 1'b0, "rs_w0");
    send(8'h66, 1'b0, "rs_w1");
    send(8'h77, 1'b0, "rs_w2");
    send(8'h88, 1'b1, "rs_w3");
    recv(8'h88, 1'b0, "rs_o0");
    recv(8'h77, 1'b0, "rs_o1");
    m_ready = 1'b0;
    for (int n = 0; n < 60 && !m_valid; n++) begin @(posedge clk); #1; end
    chk(32'(m_data), 32'h66, "rs_hold_data");
    rst = 1'b1;
    #1;
    chk(32'(m_valid), 32'd0, "rs_async_valid");
    @(posedge clk); #1;
    rst = 1'b0;
    chk(32'(m_valid), 32'd0, "rs_m_valid");
    chk(32'(s_ready), 32'd1, "rs_s_ready");
    chk(32'(dut.cnt_q), 32'd0, "rs_cnt");
    chk(32'(stk_empty), 32'd1, "rs_stk_empty");
    m_ready = 1'b1;
    send(8'hBB, 1'b1, "rs_bb_w");
    recv(8'hBB, 1'b1, "rs_bb_o");

`ifdef STACK_REVERSER_STATUS_EN
    // Empty stack reported during POP with cnt=2
    send(8'hC1, 1'b0, "er_w0");
    send(8'hC2, 1'b1, "er_w1");
    chk(32'(stk_pop), 32'd1, "er_in_pop");
    force_empty = 1'b1;
    @(posedge clk); #1;
    force_empty = 1'b0;
    chk(32'(err), 32'd1, "er_set");
    recv(8'hC2, 1'b0, "er_o0");
    recv(8'hC1, 1'b1, "er_o1");
    chk(32'(err), 32'd1, "er_sticky");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(32'(err), 32'd0, "er_cleared");
`endif

    chk(32'(overlap), 32'd0, "push_pop_overlap");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_reverser.md
Name: stack_reverser

Overview:
- Initiator for the push/pop LIFO stack interface: drives push, pop and din, and consumes dout, empty and full.
- Accepts frames of words on a valid/ready input stream and pushes each word into an external stack instance.
- On end of frame, pops the whole frame and emits it word-reversed on a valid/ready output stream.
- Sits between a producer and consumer in the datapath, beside one stack instance with matching WIDTH/DEPTH.

Parameters:
WIDTH, 8, data word width; must equal the attached stack's WIDTH
DEPTH, 8, attached stack capacity in words; maximum frame segment length

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset; must also drive the attached stack's reset
s_valid  in  1  input word valid
s_ready  out  1  input word accepted when s_valid&s_ready
s_data  in  WIDTH  input word
s_last  in  1  last word of input frame
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts
m_data  out  WIDTH  output word
m_last  out  1  last word of reversed frame
stk_push  out  1  push strobe to stack
stk_pop  out  1  pop strobe to stack
stk_din  out  WIDTH  data to stack
stk_dout  in  WIDTH  stack read data; valid the cycle after stk_pop
stk_empty  in  1  stack empty
stk_full  in  1  stack full

Behaviour:
- State machine: FILL, POP, CAP, HOLD.
- Counter cnt, width $clog2(DEPTH+1); reset value 0.
- Reset, applied asynchronously at any time, including mid-frame or mid-drain:
  - state=FILL, cnt=0, m_valid=0, m_last=0, m_data=0, stk_pop=0.
  - Any partial frame is discarded. The stack is cleared by the same rst; the block never drains it.
- FILL:
  - s_ready = ~stk_full & (cnt<DEPTH), combinational.
  - stk_push = s_valid & s_ready, and stk_din = s_data, both combinational.
  - On each accepted word, cnt++.
  - If the accepted word has s_last=1, or cnt becomes DEPTH, go to POP next cycle.
  - A DEPTH-word segment without s_last closes the segment. Later words form the next frame.
- POP:
  - stk_pop=1 for exactly one cycle, registered. s_ready=0.
  - Next state is CAP.
- CAP:
  - Register m_data<=stk_dout, m_valid<=1, cnt--, m_last<=(cnt==1).
  - Next state is HOLD.
- HOLD:
  - m_valid=1. m_data and m_last stay stable until m_ready.
  - On m_ready: m_valid<=0. If m_last, go to FILL; else go to POP.
- Throughput in drain: 3 cycles per word with m_ready held high. Latency from last input accept to first m_valid: 3 cycles.
- Simultaneous events:
  - Input is never accepted during POP/CAP/HOLD. There is no overlap of push and pop.
  - stk_push and stk_pop are never both 1.
- Boundaries:
  - A single-word frame yields one output with m_last=1.
  - A frame of exactly DEPTH words with s_last on word DEPTH is one frame, with no segmentation.
  - stk_empty asserted in POP while cnt>0 is a protocol error. The pop is still issued and CAP proceeds normally.

Optional Feature:
- Macro: STACK_REVERSER_STATUS_EN
- Defined: adds output err (1 bit, sticky until rst) and output seg (1 bit, one-cycle pulse).
  - err sets on: stk_empty=1 in POP; or stk_full=1 in FILL while cnt<DEPTH.
  - seg pulses the cycle a frame is closed by cnt reaching DEPTH without s_last.
- Undefined: err and seg ports and their logic are absent; the mismatch conditions are ignored.

Decomposition:
- Shared package stack_pkg:
  - state encoding (FILL=2'd0, POP=2'd1, CAP=2'd2, HOLD=2'd3)
  - default WIDTH/DEPTH constants
  - count-width function
- No sub-module inside the block; the stack is instanced next to it at the integration level.

Test Plan:
- Push 11,22,33,44 with s_last on 44, m_ready=1 -> m_data 44,33,22,11; m_last only on 11; exactly 4 stk_pop pulses.
- 9 words 01..09 with s_last on 09, DEPTH=8:
  - Output 08..01 with m_last on 01, then 09 with m_last.
  - seg pulses once when the feature is enabled.
- Single word AA with s_last -> one output AA, m_last=1; first m_valid 3 cycles after accept.
- During drain of 11,22,33, hold m_ready=0 for 5 cycles in HOLD -> m_data=33 stays stable; no extra stk_pop; s_ready=0.
- Assert rst while in HOLD after 2 of 4 words -> next cycle m_valid=0, s_ready=1 (stack empty), cnt=0; a new frame BB reverses correctly.
- With feature enabled, force stk_empty=1 during POP with cnt=2 -> err=1 and held until rst.
